// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, segment constants and helpers for the seven-segment I/O port.
//   state_e    - controller states (idle, converting, result ready)
//   SEG_BLANK  - all segments off (active-low)
//   SEG_DASH   - only segment g lit
//   seg_encode - 4-bit value to active-low segment code, bit 0 = segment a
//   nbcd       - BCD digit count needed for a w-bit unsigned value
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] seg;
    unique case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // ceil(w * log10(2)) + 1, in fixed point so it stays an elaboration-time integer.
  function automatic int nbcd(input int w);
    return (w * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter.
//   clk, rst  - clock, asynchronous active-high reset
//   i_start   - load i_bin and begin DATA_W add-3/shift iterations (one per edge)
//   i_bin     - unsigned binary input
//   o_done    - high during the cycle whose closing edge performs the final iteration
//   o_bcd     - BCD result, valid from that edge until the next i_start
module bin2bcd_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BCD_W  = 44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_bin,
  output logic              o_done,
  output logic [BCD_W-1:0]  o_bcd
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int          NB    = int'(BCD_W / 4);

  logic [DATA_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_adj;
  logic [CNT_W-1:0]  r_cnt;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NB; d++) begin
      if (r_bcd[4*d+:4] >= 4'd5) begin
        w_adj[4*d+:4] = r_bcd[4*d+:4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CNT_W'(DATA_W);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg7_io_port.sv
// seg7_io_port: CPU-to-board I/O port.
//   clk, rst     - clock, asynchronous active-high reset
//   wr_en        - write strobe; wr_data/wr_dec/wr_blank_lz sampled with it
//   wr_dec       - 0 = hex render (single cycle), 1 = unsigned decimal (DATA_W+1 cycles)
//   wr_blank_lz  - blank digits above the most significant nonzero digit
//   busy         - decimal conversion in progress
//   hex_out      - NDIGITS active-low 7-segment digits, digit i on [7i+6:7i]
//   sw_in        - raw asynchronous switches
//   sw_sync      - synchronised switches, zero-extended to DATA_W
module seg7_io_port
  import seg7_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NDIGITS     = 8,
  parameter int unsigned SW_W        = 18,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_dec,
  input  logic                 wr_blank_lz,
  output logic                 busy,
  output logic [7*NDIGITS-1:0] hex_out,
  input  logic [SW_W-1:0]      sw_in,
  output logic [DATA_W-1:0]    sw_sync
);

  localparam int unsigned HW         = 4 * NDIGITS;
  localparam int unsigned BCD_W      = 4 * nbcd(DATA_W);
  localparam int          HEX_DIGITS = int'((DATA_W + 3) / 4);

  state_e               r_state, w_state_next;
  logic [7*NDIGITS-1:0] r_hex, w_hex_next;
  logic                 r_blz, w_blz_next;
  logic                 r_pend_vld, w_pend_vld_next;
  logic [DATA_W-1:0]    r_pend_data, w_pend_data_next;
  logic                 r_pend_dec, w_pend_dec_next;
  logic                 r_pend_blz, w_pend_blz_next;

  logic                 w_cmd_vld;
  logic [DATA_W-1:0]    w_cmd_data;
  logic                 w_cmd_dec;
  logic                 w_cmd_blz;
  logic                 w_start;
  logic                 w_done;
  logic [BCD_W-1:0]     w_bcd;
  logic [HW-1:0]        w_hex_nib, w_dec_nib;
  logic                 w_ovf;
  logic [7*NDIGITS-1:0] w_hex_seg, w_dec_seg;

  // Digits at or above nreal are always blank; with blz, zeros above the top
  // nonzero digit are blanked but digit 0 is always drawn.
  function automatic logic [7*NDIGITS-1:0] render(input logic [HW-1:0] nib, input int nreal,
                                                  input logic blz);
    logic [7*NDIGITS-1:0] seg;
    logic                 seen;
    seg  = {NDIGITS{SEG_BLANK}};
    seen = 1'b0;
    for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
      if (i < nreal) begin
        if (nib[4*i+:4] != 4'h0 || i == 0) seen = 1'b1;
        if (!blz || seen) seg[7*i+:7] = seg_encode(nib[4*i+:4]);
      end
    end
    return seg;
  endfunction

  bin2bcd_seq #(
    .DATA_W(DATA_W),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_bin  (w_cmd_data),
    .o_done (w_done),
    .o_bcd  (w_bcd)
  );

  // Command source: a live write, or in DONE the pending slot when nobody writes.
  always_comb begin
    w_cmd_vld  = 1'b0;
    w_cmd_data = wr_data;
    w_cmd_dec  = wr_dec;
    w_cmd_blz  = wr_blank_lz;
    if (r_state == StIdle) begin
      w_cmd_vld = wr_en;
    end else if (r_state == StDone) begin
      if (wr_en) begin
        w_cmd_vld = 1'b1;
      end else if (r_pend_vld) begin
        w_cmd_vld  = 1'b1;
        w_cmd_data = r_pend_data;
        w_cmd_dec  = r_pend_dec;
        w_cmd_blz  = r_pend_blz;
      end
    end
  end

  always_comb begin
    w_hex_nib = '0;
    w_dec_nib = '0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      w_hex_nib[4*i+:4] = 4'(w_cmd_data >> (4 * i));
      w_dec_nib[4*i+:4] = 4'(w_bcd >> (4 * i));
    end
  end

  assign w_ovf     = |(w_bcd >> HW);
  assign w_hex_seg = render(w_hex_nib, HEX_DIGITS, w_cmd_blz);
  assign w_dec_seg = w_ovf ? {NDIGITS{SEG_DASH}} : render(w_dec_nib, int'(NDIGITS), r_blz);

  always_comb begin
    w_state_next     = r_state;
    w_hex_next       = r_hex;
    w_blz_next       = r_blz;
    w_pend_vld_next  = r_pend_vld;
    w_pend_data_next = r_pend_data;
    w_pend_dec_next  = r_pend_dec;
    w_pend_blz_next  = r_pend_blz;
    w_start          = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cmd_vld) begin
          if (w_cmd_dec) begin
            w_start      = 1'b1;
            w_blz_next   = w_cmd_blz;
            w_state_next = StConv;
          end else begin
            w_hex_next = w_hex_seg;
          end
        end
      end
      StConv: begin
        if (wr_en) begin
          w_pend_vld_next  = 1'b1;
          w_pend_data_next = wr_data;
          w_pend_dec_next  = wr_dec;
          w_pend_blz_next  = wr_blank_lz;
        end
        if (w_done) w_state_next = StDone;
      end
      StDone: begin
        // Slot is either consumed here or discarded by a live write.
        w_pend_vld_next = 1'b0;
        w_hex_next      = w_dec_seg;
        w_state_next    = StIdle;
        if (w_cmd_vld) begin
          if (w_cmd_dec) begin
            w_start      = 1'b1;
            w_blz_next   = w_cmd_blz;
            w_state_next = StConv;
          end else begin
            w_hex_next = w_hex_seg;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_hex       <= {NDIGITS{SEG_BLANK}};
      r_blz       <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_pend_dec  <= 1'b0;
      r_pend_blz  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hex       <= w_hex_next;
      r_blz       <= w_blz_next;
      r_pend_vld  <= w_pend_vld_next;
      r_pend_data <= w_pend_data_next;
      r_pend_dec  <= w_pend_dec_next;
      r_pend_blz  <= w_pend_blz_next;
    end
  end

  assign busy    = (r_state != StIdle);
  assign hex_out = r_hex;

  logic [SW_W-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= sw_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) r_sync[s] <= r_sync[s-1];
    end
  end

  always_comb begin
    sw_sync            = '0;
    sw_sync[SW_W-1:0]  = r_sync[SYNC_STAGES-1];
  end

endmodule

// File: tb/tb_seg7_io_port.sv
module tb_seg7_io_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_dec = 1'b0;
  logic        wr_blank_lz = 1'b0;
  logic [31:0] wr_data = '0;
  logic [17:0] sw_in = '0;
  logic        busy, busy10;
  logic [55:0] hex8;
  logic [69:0] hex10;
  logic [31:0] sw_sync, sw_sync10;

  int checks = 0;
  int failures = 0;
  int nruns = 0;
  int last_run = 0;
  logic [79:0] exp_q[$];

  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                          7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                                          7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_io_port u_dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dec(wr_dec),
    .wr_blank_lz(wr_blank_lz), .busy(busy), .hex_out(hex8), .sw_in(sw_in), .sw_sync(sw_sync)
  );

  seg7_io_port #(.NDIGITS(10)) u_dut10 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dec(wr_dec),
    .wr_blank_lz(wr_blank_lz), .busy(busy10), .hex_out(hex10), .sw_in(sw_in),
    .sw_sync(sw_sync10)
  );

  function automatic logic [79:0] show(input int dig[16], input int nreal, input int nd,
                                       input bit blz);
    logic [79:0] r;
    int top;
    r = '0;
    top = 0;
    for (int i = 0; i < nd; i++) if (i < nreal && dig[i] != 0) top = i;
    for (int i = 0; i < nd; i++)
      r[7*i+:7] = (i >= nreal || (blz && i > top)) ? 7'h7F : SEG_TBL[dig[i]];
    return r;
  endfunction

  function automatic logic [79:0] model_hex(input logic [31:0] v, input bit blz, input int nd);
    int dig[16];
    for (int i = 0; i < 16; i++) dig[i] = (i < 8) ? int'((v >> (4 * i)) & 32'hF) : 0;
    return show(dig, 8, nd, blz);
  endfunction

  function automatic logic [79:0] model_dec(input longint unsigned v, input bit blz,
                                            input int nd);
    int dig[16];
    longint unsigned lim;
    logic [79:0] r;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v >= lim) begin
      r = '0;
      for (int i = 0; i < nd; i++) r[7*i+:7] = 7'h3F;
      return r;
    end
    for (int i = 0; i < 16; i++) begin
      dig[i] = int'(v % 10);
      v = v / 10;
    end
    return show(dig, nd, nd, blz);
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_wr(input logic [31:0] d, input logic dec, input logic blz);
    wr_en = 1'b1;
    wr_data = d;
    wr_dec = dec;
    wr_blank_lz = blz;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Waits (bounded) for the busy run that began after n0 runs to complete.
  task automatic wait_run(input string tag, input int n0, input int exp_len);
    #1;
    for (int k = 0; k < 300; k++) begin
      if (nruns != n0) break;
      @(negedge clk);
      #1;
    end
    check({tag, "_ended"}, 80'(nruns != n0), 80'(1));
    check({tag, "_busy_len"}, 80'(last_run), 80'(exp_len));
  endtask

  initial begin
    logic [55:0] prev;
    int run;
    int n0;
    logic [17:0] v;
    logic [17:0] hist[$];
    prev = '1;
    run = 0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          prev = hex8;
        end else if (hex8 !== prev) begin
          if (exp_q.size() == 0) check("unexpected_update", {24'b0, hex8}, {24'b0, prev});
          else check("display", {24'b0, hex8}, exp_q.pop_front());
          prev = hex8;
        end
      end
      forever begin
        @(negedge clk);
        if (rst) run = 0;
        else if (busy) run++;
        else if (run != 0) begin
          last_run = run;
          nruns++;
          run = 0;
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state, with switches active so the synchroniser must hold zero.
    sw_in = 18'h3FFFF;
    idle(3);
    check("reset_hex8", {24'b0, hex8}, {24'b0, {8{7'h7F}}});
    check("reset_hex10", {10'b0, hex10}, {10'b0, {10{7'h7F}}});
    check("reset_busy", 80'(busy), 80'(0));
    check("reset_sw", 80'(sw_sync), 80'(0));
    rst = 1'b0;
    idle(3);
    check("sw_after_reset", 80'(sw_sync), 80'(32'h3FFFF));

    // Abort a conversion (with a pending hex write) by reset.
    drive_wr(32'd999, 1'b1, 1'b0);
    drive_wr(32'h55, 1'b0, 1'b0);
    idle(3);
    check("conv_busy", 80'(busy), 80'(1));
    #2 rst = 1'b1;
    #1;
    check("abort_hex8", {24'b0, hex8}, {24'b0, {8{7'h7F}}});
    check("abort_busy", 80'(busy), 80'(0));
    check("abort_sw", 80'(sw_sync), 80'(0));
    idle(2);
    rst = 1'b0;
    idle(40);
    check("abort_stays_idle", 80'(busy), 80'(0));
    check("abort_no_run", 80'(nruns), 80'(0));

    // Hex write: updates at the sampling edge, never busy.
    n0 = nruns;
    exp_q.push_back(model_hex(32'h0000_BEEF, 1'b0, 8));
    drive_wr(32'h0000_BEEF, 1'b0, 1'b0);
    #1;
    check("hex_busy", 80'(busy), 80'(0));
    check("hex_q_drained", 80'(exp_q.size()), 80'(0));
    idle(3);
    check("hex_never_busy", 80'(nruns), 80'(n0));

    // Decimal with leading-zero blanking.
    n0 = nruns;
    exp_q.push_back(model_dec(64'd12345, 1'b1, 8));
    drive_wr(32'd12345, 1'b1, 1'b1);
    wait_run("dec12345", n0, 33);
    idle(1);
    check("dec12345_q", 80'(exp_q.size()), 80'(0));

    // Max value: overflows 8 digits, fits in 10.
    n0 = nruns;
    exp_q.push_back(model_dec(64'd4294967295, 1'b0, 8));
    drive_wr(32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_run("decmax", n0, 33);
    idle(1);
    check("decmax_nd10", {10'b0, hex10}, model_dec(64'd4294967295, 1'b0, 10));
    check("decmax_q", 80'(exp_q.size()), 80'(0));

    // Zero with blanking shows a single 0.
    n0 = nruns;
    exp_q.push_back(model_dec(64'd0, 1'b1, 8));
    drive_wr(32'd0, 1'b1, 1'b1);
    wait_run("dec0", n0, 33);
    idle(1);
    check("dec0_q", 80'(exp_q.size()), 80'(0));

    // Pending slot: last writer wins, 'hA never shown, busy continuous.
    n0 = nruns;
    exp_q.push_back(model_dec(64'd100, 1'b0, 8));
    exp_q.push_back(model_dec(64'd7, 1'b0, 8));
    drive_wr(32'd100, 1'b1, 1'b0);
    idle(2);
    drive_wr(32'hA, 1'b0, 1'b0);
    idle(1);
    drive_wr(32'd7, 1'b1, 1'b0);
    wait_run("pend", n0, 66);
    idle(1);
    check("pend_q", 80'(exp_q.size()), 80'(0));

    // Write in the DONE cycle beats the pending slot, which is discarded.
    n0 = nruns;
    exp_q.push_back(model_hex(32'h1234, 1'b1, 8));
    drive_wr(32'd55, 1'b1, 1'b0);
    idle(4);
    drive_wr(32'd9, 1'b1, 1'b0);
    idle(27);
    drive_wr(32'h1234, 1'b0, 1'b1);
    wait_run("doneprio", n0, 33);
    idle(40);
    check("doneprio_no_restart", 80'(nruns), 80'(n0 + 1));
    check("doneprio_q", 80'(exp_q.size()), 80'(0));

    // Switch synchroniser latency.
    sw_in = 18'd12345;
    @(negedge clk);
    check("sw_lat1", 80'(sw_sync), 80'(32'h3FFFF));
    @(negedge clk);
    check("sw_lat2", 80'(sw_sync), 80'(32'd12345));
    for (int n = 0; n < 16; n++) begin
      if (n >= 2) check("sw_follow", 80'(sw_sync), 80'(hist[n-2]));
      v = sw_in ^ 18'($urandom_range(1, 262143));
      sw_in = v;
      hist.push_back(v);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
